// File: rtl/d16_fetch_if.sv
// Instruction memory port between the fetch stage and a synchronous-read memory.
interface d16_fetch_if;
  logic [15:0] imem_adr;
  logic [31:0] imem_dat;

  modport master (output imem_adr, input imem_dat);
  modport slave  (input imem_adr, output imem_dat);
endinterface

// File: rtl/d16_fetch.sv
// Fetch stage of the d16 pipeline: drives instruction memory and fills the
// LI/DI register, handling stalls, taken-branch flushes and perf counters.
module d16_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic               jmp,
  input  logic [15:0]        jmp_addr,
  d16_fetch_if.master        imem,
  output logic [7:0]         li_di_op,
  output logic [15:0]        li_di_a,
  output logic [15:0]        li_di_b,
  output logic [15:0]        li_di_c,
  output logic [15:0]        li_di_pc,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] fetch_pc;
  logic        do_flush;
  logic        do_stall;
  logic        do_adv;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= BOOT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (jmp)                state_nxt = FLUSH;
    else if (state == BOOT) state_nxt = RUN;
    else if (!en)           state_nxt = STALL;
    else                    state_nxt = RUN;
  end

  // A redirect wins everywhere; BOOT ignores en and only inserts a bubble.
  always_comb begin
    do_flush = jmp;
    do_stall = !jmp && (state != BOOT) && !en;
    do_adv   = !jmp && (state != BOOT) && en;
    if (sys_rst)     imem.imem_adr = RESET_PC;
    else if (jmp)    imem.imem_adr = jmp_addr;
    else if (do_adv) imem.imem_adr = fetch_pc + 16'd1;
    else             imem.imem_adr = fetch_pc;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      fetch_pc  <= RESET_PC;
      li_di_op  <= 8'h00;
      li_di_a   <= 16'h0000;
      li_di_b   <= 16'h0000;
      li_di_c   <= 16'h0000;
      li_di_pc  <= RESET_PC;
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else if (do_flush) begin
      fetch_pc <= jmp_addr;
      li_di_op <= 8'h00;
      li_di_a  <= 16'h0000;
      li_di_b  <= 16'h0000;
      li_di_c  <= 16'h0000;
      if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end else if (do_stall) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end else if (do_adv) begin
      li_di_op <= imem.imem_dat[31:24];
      li_di_a  <= {8'h00, imem.imem_dat[23:16]};
      li_di_b  <= {8'h00, imem.imem_dat[15:8]};
      li_di_c  <= {8'h00, imem.imem_dat[7:0]};
      li_di_pc <= fetch_pc;
      fetch_pc <= fetch_pc + 16'd1;
    end else begin
      li_di_op <= 8'h00;
      li_di_a  <= 16'h0000;
      li_di_b  <= 16'h0000;
      li_di_c  <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_d16_fetch.sv
// Bench for d16_fetch: directed scenarios plus random en/jmp/reset traffic
// compared against an instruction-stream model of the fetch stage.
module tb_d16_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        en;
  logic        jmp;
  logic [15:0] jmp_addr;

  d16_fetch_if mif_a ();
  d16_fetch_if mif_b ();

  logic [7:0]  a_op, b_op;
  logic [15:0] a_a, a_b, a_c, a_pc, a_stall, a_flush;
  logic [15:0] b_a, b_b, b_c, b_pc, b_stall, b_flush;

  d16_fetch #(.RESET_PC(16'h0000)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .jmp(jmp), .jmp_addr(jmp_addr),
    .imem(mif_a), .li_di_op(a_op), .li_di_a(a_a), .li_di_b(a_b), .li_di_c(a_c),
    .li_di_pc(a_pc), .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  d16_fetch #(.RESET_PC(16'hFFFE)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .jmp(jmp), .jmp_addr(jmp_addr),
    .imem(mif_b), .li_di_op(b_op), .li_di_a(b_a), .li_di_b(b_b), .li_di_c(b_c),
    .li_di_pc(b_pc), .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] mem_word(input logic [15:0] addr);
    return {addr[7:0], 24'h010203};
  endfunction

  always @(posedge sys_clk) begin
    mif_a.imem_dat <= mem_word(mif_a.imem_adr);
    mif_b.imem_dat <= mem_word(mif_b.imem_adr);
  end

  // Model: m_next is the address of the next instruction to be delivered.
  logic        m_boot;
  logic [15:0] m_next;
  logic [7:0]  m_op;
  logic [15:0] m_a, m_b, m_c, m_pc, m_stall, m_flush;
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_i, input logic en_i, input logic jmp_i,
                               input logic [15:0] addr_i);
    logic [15:0] exp_adr;
    logic [31:0] w;
    sys_rst  = rst_i;
    en       = en_i;
    jmp      = jmp_i;
    jmp_addr = addr_i;
    #2;
    if (rst_i)               exp_adr = 16'h0000;
    else if (jmp_i)          exp_adr = addr_i;
    else if (m_boot || !en_i) exp_adr = m_next;
    else                     exp_adr = m_next + 16'd1;
    checkOutput("imem_adr", mif_a.imem_adr, exp_adr);
    @(posedge sys_clk);
    #1;
    if (rst_i) begin
      m_boot = 1'b1; m_next = 16'h0000; m_pc = 16'h0000;
      m_op = 8'h00; m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
      m_stall = 16'h0; m_flush = 16'h0;
    end else if (jmp_i) begin
      m_boot = 1'b0; m_next = addr_i;
      m_op = 8'h00; m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
      if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_op = 8'h00; m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
    end else if (!en_i) begin
      if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end else begin
      w = mem_word(m_next);
      m_op = w[31:24]; m_a = {8'h00, w[23:16]}; m_b = {8'h00, w[15:8]}; m_c = {8'h00, w[7:0]};
      m_pc = m_next;
      m_next = m_next + 16'd1;
    end
    checkOutput("li_di_op", {8'h00, a_op}, {8'h00, m_op});
    checkOutput("li_di_a", a_a, m_a);
    checkOutput("li_di_b", a_b, m_b);
    checkOutput("li_di_c", a_c, m_c);
    checkOutput("li_di_pc", a_pc, m_pc);
    checkOutput("stall_cnt", a_stall, m_stall);
    checkOutput("flush_cnt", a_flush, m_flush);
    n_vec++;
  endtask

  initial begin
    logic [15:0] exp_b;
    logic [15:0] r_addr;
    logic        r_rst, r_en, r_jmp;
    m_boot = 1'b1; m_next = 16'h0; m_pc = 16'h0; m_op = 8'h0;
    m_a = 16'h0; m_b = 16'h0; m_c = 16'h0; m_stall = 16'h0; m_flush = 16'h0;

    applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    checkOutput("b_reset_pc", b_pc, 16'hFFFE);
    checkOutput("b_reset_op", {8'h00, b_op}, 16'h0000);

    // Straight-line run; the second instance shows the FFFF -> 0000 wrap.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
      if (i >= 2 && i <= 4) begin
        exp_b = 16'hFFFE + 16'(i - 2);
        checkOutput("b_wrap_pc", b_pc, exp_b);
        checkOutput("b_wrap_op", {8'h00, b_op}, {8'h00, exp_b[7:0]});
      end
    end
    checkOutput("run_pc5", a_pc, 16'h0005);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("stall_pc5", a_pc, 16'h0005);
    checkOutput("stall_cnt3", a_stall, 16'h0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("resume_pc6", a_pc, 16'h0006);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("resume_pc7", a_pc, 16'h0007);

    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
    checkOutput("jmp_bubble_op", {8'h00, a_op}, 16'h0000);
    checkOutput("jmp_flush1", a_flush, 16'h0001);
    checkOutput("jmp_stall_keep", a_stall, 16'h0003);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("jmp_target_pc", a_pc, 16'h0040);

    // Random traffic: reset, redirects (incl. to the current pc), stalls.
    for (int i = 0; i < 400; i++) begin
      r_rst  = ($urandom_range(63, 0) == 0);
      r_jmp  = ($urandom_range(5, 0) == 0) && !m_boot;
      r_en   = ($urandom_range(3, 0) != 0);
      case ($urandom_range(3, 0))
        0:       r_addr = m_next;
        1:       r_addr = 16'hFFFD + 16'($urandom_range(2, 0));
        default: r_addr = 16'($urandom);
      endcase
      applyStimulus(r_rst, r_en, r_jmp, r_addr);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("pre_rst_stall10", a_stall, 16'd10);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'h0777);
    checkOutput("rst_stall_cnt", a_stall, 16'h0000);
    checkOutput("rst_flush_cnt", a_flush, 16'h0000);
    checkOutput("rst_pc", a_pc, 16'h0000);
    checkOutput("rst_op", {8'h00, a_op}, 16'h0000);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 65536; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("stall_sat", a_stall, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    checkOutput("stall_sat_hold", a_stall, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/d16_fetch.md
D16_FETCH -- requirements
Module: d16_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the instruction word address fetched first after reset.
REQ-002 sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-003 sys_rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  advance enable from the hazard unit; 1 = advance, 0 = stall the LI/DI stage.
REQ-005 jmp  input  1  taken-branch redirect from downstream.
REQ-006 jmp_addr  input  16  redirect target word address, qualified by jmp.
REQ-007 imem_adr  output  16  instruction memory word address, combinational from current state and inputs.
REQ-008 imem_dat  input  32  instruction word, synchronous read, valid one cycle after imem_adr.
REQ-009 li_di_op  output  8  registered opcode presented to the decode stage.
REQ-010 li_di_a, li_di_b, li_di_c  output  16 each  registered operand fields.
REQ-011 li_di_pc  output  16  registered word address of the instruction in li_di_*.
REQ-012 stall_cnt, flush_cnt  output  16 each  performance counters.

Function
REQ-013 Instruction word split: op = imem_dat[31:24]; a, b, c = imem_dat[23:16], [15:8], [7:0], each zero-extended to 16 bits.
REQ-014 Register fetch_pc holds the address whose data is on imem_dat in the current cycle.
REQ-015 The NOP bubble is op = 8'h00 with a = b = c = 0; li_di_pc is unchanged by a bubble.
REQ-016 State machine states: BOOT, RUN, STALL, FLUSH; the state register is for observability only, and all outputs follow REQ-017..REQ-021.
REQ-017 Priority in every non-BOOT state: jmp, then en = 0, then normal advance.
REQ-018 jmp = 1:
  - imem_adr = jmp_addr; fetch_pc <= jmp_addr.
  - li_di_* <= NOP; next state FLUSH.
  - the word currently on imem_dat is discarded.
  - en is ignored in this cycle.
REQ-019 jmp = 0, en = 0:
  - imem_adr = fetch_pc, so the same word is re-read and imem_dat stays valid next cycle.
  - fetch_pc, li_di_* and li_di_pc hold; next state STALL.
REQ-020 jmp = 0, en = 1:
  - li_di_* <= fields of imem_dat; li_di_pc <= fetch_pc.
  - imem_adr = fetch_pc + 1, mod 2^16 (16'hFFFF wraps to 16'h0000); fetch_pc <= fetch_pc + 1.
  - next state RUN.
REQ-021 BOOT, the first cycle after reset:
  - imem_adr = fetch_pc; li_di_* <= NOP.
  - next state RUN, or FLUSH with the REQ-018 action if jmp = 1.
REQ-022 Throughput is one instruction per cycle in RUN.
REQ-023 Latency from a jmp cycle to the target instruction in li_di_* is 2 cycles, with exactly one bubble.
REQ-024 stall_cnt increments by 1 on every cycle matching REQ-019 and saturates at 16'hFFFF.
REQ-025 flush_cnt increments by 1 on every cycle matching REQ-018 and saturates at 16'hFFFF.
REQ-026 jmp with jmp_addr equal to fetch_pc behaves exactly as any other redirect: one bubble, then the target.
REQ-027 Back-to-back jmp cycles each squash and redirect; the last jmp_addr wins.

Reset
REQ-028 While sys_rst = 1:
  - imem_adr = RESET_PC; fetch_pc <= RESET_PC; li_di_* <= NOP.
  - li_di_pc <= RESET_PC; stall_cnt, flush_cnt <= 0; state <= BOOT.
REQ-029 Reset asserted mid-stall or mid-flush overrides all inputs within the same cycle; no partial update survives.
REQ-030 Reset values are independent of en, jmp and imem_dat.

Verification
REQ-031 Reset then en = 1, memory[i] = {i[7:0], 24'h010203}:
  - li_di_op is 00 in the first cycle after BOOT, then 00, 01, 02, ... on consecutive cycles.
  - li_di_pc is 0, 1, 2, ...; imem_adr is 1, 2, 3, ...
REQ-032 en = 0 for 3 cycles while li_di holds pc 5:
  - li_di_* and li_di_pc stay at pc 5, and imem_adr = 6 for the whole stall.
  - after en returns to 1: pc 6, then pc 7, with no loss and no duplicate.
  - stall_cnt = 3.
REQ-033 jmp = 1, jmp_addr = 16'h0040 while en = 0:
  - next cycle li_di_op = 00; the following cycle li_di_pc = 16'h0040.
  - flush_cnt = 1; stall_cnt unchanged.
REQ-034 With RESET_PC = 16'hFFFE, run 3 cycles: li_di_pc sequence FFFE, FFFF, 0000.
REQ-035 sys_rst asserted during STALL with stall_cnt = 10:
  - next cycle all outputs are at their REQ-028 values and stall_cnt = 0.
REQ-036 Force stall_cnt to 16'hFFFF via a long stall, then one more stall cycle: stall_cnt remains 16'hFFFF.
